pipelined_floating_point_multiplier: RTL and testbench
======================================================

# pipelined_floating_point_multiplier

Three-stage, valid/ready-handshaked floating-point multiplier, parametrised in exponent and mantissa width, with a per-operation rounding mode and sticky exception flags. It is the clocked successor of the combinational multiplier and sits between operand-issue logic and a result consumer (accumulator, writeback FIFO) that may apply backpressure. Subnormal inputs are flushed to zero (DAZ).

## Interface
- EXPONENT_WIDTH, 8, exponent field width (≥3)
- MANTISSA_WIDTH, 23, stored mantissa width (≥2)
- IGNORE_SIGN_BIT_FOR_NAN, 1, 1: NaN detection ignores sign; 0: only sign=1 patterns are NaN
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- a, b  in  EXPONENT_WIDTH+MANTISSA_WIDTH+1 each  operands {sign, exponent, mantissa}
- round_mode  in  1  0: round toward zero, 1: round to nearest, ties to even; sampled with operands
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out  out  EXPONENT_WIDTH+MANTISSA_WIDTH+1  product
- underflow_flag, overflow_flag, invalid_operation_flag  out  1 each  per-result flags, qualified by out_valid
- clear_flags  in  1  clears sticky flags
- sticky_underflow, sticky_overflow, sticky_invalid  out  1 each  OR of flags of all results handed off since the last clear

## Operation
- Stage 1: unpack; classify zero (exp=0, incl. subnormal → DAZ), infinity, sNaN (exp all ones, mantissa MSB 0, mantissa≠0), qNaN (exp all ones, mantissa MSB 1); sign = a_sign^b_sign; exponent sum a_exp+b_exp−bias in EXPONENT_WIDTH+2 signed bits; bias = 2^(EXPONENT_WIDTH−1)−1.
- Stage 2: (MANTISSA_WIDTH+1)×(MANTISSA_WIDTH+1) significand multiply, full 2·(MANTISSA_WIDTH+1)-bit product registered.
- Stage 3: normalise (product MSB set → shift right 1, exponent+1), round, detect range errors, select special results.
- Rounding: guard = first dropped bit, sticky = OR of remaining dropped bits; RNE increments when guard && (sticky || lsb); RTZ truncates. Mantissa carry-out increments exponent.
- Priority: NaN operand → quiet NaN {1, all ones, 1, zeros}; E4M3 uses all-ones mantissa. invalid set only for an sNaN operand or 0×∞.
- 0×∞ → quiet NaN, invalid. ∞×(finite or ∞) → signed ∞, no flag. 0×finite → signed zero, no flag.
- Final exponent ≥ all ones (including after rounding carry) → signed ∞, overflow.
- Final exponent ≤ 0 → signed zero, underflow.

## Timing
- Global advance enable = !out_valid || out_ready; all stages shift together; in_ready = enable (combinational from out_valid/out_ready, no path from in_valid).
- Latency 3 cycles from accepted input to out_valid under no backpressure; throughput 1 op/cycle.
- out_valid && !out_ready: out, per-result flags and out_valid hold stable; pipeline holds; bubbles do not compress.
- Sticky flags update on output handshake (out_valid && out_ready). Same cycle as clear_flags: new flag value wins (set), other bits clear.
- Reset: out_valid, all stage valids, sticky flags, per-result flags = 0; out = 0. Reset mid-operation discards in-flight operands with no output.

## Structure
- Shared package fp_pkg: float field-extraction constants, bias function, quiet-NaN constructor, round-mode enum (RTZ=0, RNE=1).
- Sub-module fp_round_normalise (stage-3 combinational normalise+round+range check); special-value classification reuses the existing is_special_float.

## Test plan
- FP32 0x3FC00000 × 0x40000000, out_ready=1 → 0x40400000 three cycles later, no flags.
- 0x3F800001 × 0x40400000: RNE → 0x40400002; RTZ → 0x40400001 (tie case).
- 0x7F000000 × 0x40000000 → 0x7F800000, overflow, sticky_overflow stays set until clear_flags.
- 0x00000000 × 0x7F800000 → 0xFFC00000, invalid; 0x7FC00000 × 0x3F800000 → 0xFFC00000, no invalid.
- out_ready low for 6 cycles with in_valid high → exactly 3 operands accepted, then in_ready=0, out stable; release → results in order, no loss or duplicate.
- Assert rst_n low with 2 ops in flight → out_valid=0 immediately, no results emerge after release; E4M3 (4,3) and FP16 (5,10) random runs vs. reference model.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared float field helpers, bias, quiet-NaN constructor and round-mode enum
package fp_pkg;
    typedef enum logic {RTZ = 1'b0, RNE = 1'b1} round_mode_e;
    function automatic int exp_bias(int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    function automatic logic [63:0] exp_ones(int ew, int mw);
        return ((64'd1 << ew) - 64'd1) << mw;
    endfunction
    // E4M3 has no infinity encoding to dodge, so its NaN takes the whole mantissa
    function automatic logic [63:0] quiet_nan(int ew, int mw);
        return (64'd1 << (ew + mw)) | exp_ones(ew, mw) |
               ((ew == 4 && mw == 3) ? ((64'd1 << mw) - 64'd1) : (64'd1 << (mw - 1)));
    endfunction
endpackage

// File: rtl/fp_round_normalise.sv
// fp_round_normalise: normalises the significand product, rounds RTZ/RNE and flags exponent range errors
module fp_round_normalise #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic [2*MW+1:0]      prod,
    input  logic signed [EW+1:0] exp_in,
    input  logic                 rne,
    output logic [EW-1:0]        exp_out,
    output logic [MW-1:0]        mant,
    output logic                 overflow,
    output logic                 underflow
);
    logic [2*MW:0] norm;
    logic guard, sticky, inc;
    logic [MW:0] rounded;
    logic signed [EW+1:0] exp_f;
    always_comb begin
        norm = prod[2*MW+1] ? prod[2*MW:0] : {prod[2*MW-1:0], 1'b0};
        guard = norm[MW];
        sticky = |norm[MW-1:0];
        inc = rne && guard && (sticky || norm[MW+1]);
        rounded = {1'b0, norm[2*MW:MW+1]} + {{MW{1'b0}}, inc};
        exp_f = exp_in + {{(EW+1){1'b0}}, prod[2*MW+1]} + {{(EW+1){1'b0}}, rounded[MW]};
        exp_out = exp_f[EW-1:0];
        mant = rounded[MW-1:0];
        overflow = !exp_f[EW+1] && (exp_f[EW:0] >= {1'b0, {EW{1'b1}}});
        underflow = exp_f[EW+1] || (exp_f == '0);
    end
endmodule

// File: rtl/pipelined_floating_point_multiplier.sv
// pipelined_floating_point_multiplier: three-stage valid/ready float multiplier with DAZ, RTZ/RNE rounding and sticky flags
module pipelined_floating_point_multiplier
    import fp_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter bit IGNORE_SIGN_BIT_FOR_NAN = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  b,
    input  logic                                    round_mode,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  out,
    output logic                                    underflow_flag,
    output logic                                    overflow_flag,
    output logic                                    invalid_operation_flag,
    input  logic                                    clear_flags,
    output logic                                    sticky_underflow,
    output logic                                    sticky_overflow,
    output logic                                    sticky_invalid
);
    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    localparam int W = EW + MW + 1;
    localparam int SW = MW + 1;
    localparam int XW = EW + 2;
    localparam logic [W-1:0] QNAN = W'(quiet_nan(EW, MW));
    localparam logic signed [XW-1:0] BIAS = XW'(exp_bias(EW));

    logic en, hs;
    logic [EW-1:0] ea, eb, exp_r;
    logic [MW-1:0] fa, fb, mant_r;
    logic nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, zero_inf;
    logic v1, v2, s1, s2, nan1, nan2, inv1, inv2, inf1, inf2, zero1, zero2;
    round_mode_e rm1, rm2;
    logic signed [XW-1:0] exp1, exp2;
    logic [SW-1:0] ma1, mb1;
    logic [2*SW-1:0] prod2;
    logic ovf, unf, spec, of_c, uf_c;
    logic [W-1:0] res;

    assign en = !out_valid || out_ready;
    assign in_ready = en;
    assign hs = out_valid && out_ready;

    assign ea = a[W-2:MW];
    assign eb = b[W-2:MW];
    assign fa = a[MW-1:0];
    assign fb = b[MW-1:0];
    assign nan_a = &ea && |fa && (IGNORE_SIGN_BIT_FOR_NAN || a[W-1]);
    assign nan_b = &eb && |fb && (IGNORE_SIGN_BIT_FOR_NAN || b[W-1]);
    assign snan_a = nan_a && !fa[MW-1];
    assign snan_b = nan_b && !fb[MW-1];
    assign inf_a = &ea && !nan_a;
    assign inf_b = &eb && !nan_b;
    // subnormals collapse into zero here (DAZ)
    assign zero_a = ~|ea;
    assign zero_b = ~|eb;
    assign zero_inf = (zero_a && inf_b) || (inf_a && zero_b);

    always_ff @(posedge clk) begin
        if (en) begin
            s1 <= a[W-1] ^ b[W-1];
            rm1 <= round_mode_e'(round_mode);
            nan1 <= nan_a || nan_b || zero_inf;
            inv1 <= snan_a || snan_b || zero_inf;
            inf1 <= inf_a || inf_b;
            zero1 <= zero_a || zero_b;
            exp1 <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
            ma1 <= {1'b1, fa};
            mb1 <= {1'b1, fb};
            s2 <= s1;
            rm2 <= rm1;
            nan2 <= nan1;
            inv2 <= inv1;
            inf2 <= inf1;
            zero2 <= zero1;
            exp2 <= exp1;
            prod2 <= (2*SW)'(ma1) * (2*SW)'(mb1);
        end
    end

    fp_round_normalise #(.EW(EW), .MW(MW)) u_round (
        .prod(prod2),
        .exp_in(exp2),
        .rne(rm2 == RNE),
        .exp_out(exp_r),
        .mant(mant_r),
        .overflow(ovf),
        .underflow(unf)
    );

    assign spec = nan2 || inf2 || zero2;
    assign of_c = ovf && !spec;
    assign uf_c = unf && !spec;
    assign res = nan2 ? QNAN :
                 (inf2 || of_c) ? {s2, {EW{1'b1}}, {MW{1'b0}}} :
                 (zero2 || uf_c) ? {s2, {(W-1){1'b0}}} :
                 {s2, exp_r, mant_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            out <= '0;
            underflow_flag <= 1'b0;
            overflow_flag <= 1'b0;
            invalid_operation_flag <= 1'b0;
            sticky_underflow <= 1'b0;
            sticky_overflow <= 1'b0;
            sticky_invalid <= 1'b0;
        end else begin
            if (en) begin
                v1 <= in_valid;
                v2 <= v1;
                out_valid <= v2;
                out <= res;
                underflow_flag <= v2 && uf_c;
                overflow_flag <= v2 && of_c;
                invalid_operation_flag <= v2 && inv2;
            end
            sticky_underflow <= (sticky_underflow && !clear_flags) || (hs && underflow_flag);
            sticky_overflow <= (sticky_overflow && !clear_flags) || (hs && overflow_flag);
            sticky_invalid <= (sticky_invalid && !clear_flags) || (hs && invalid_operation_flag);
        end
    end
endmodule

// File: tb/tb_pipelined_floating_point_multiplier.sv
// tb_pipelined_floating_point_multiplier: FP32/E4M3/FP16 instances checked against an exact-arithmetic reference model
module tb_pipelined_floating_point_multiplier;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid[3], in_ready[3], rm[3], out_valid[3], out_ready[3];
    logic uf[3], of[3], inv[3], clr[3], s_uf[3], s_of[3], s_inv[3];
    logic [63:0] a[3], b[3], res[3];
    logic [66:0] sb[3][$];
    logic [2:0] st[3];
    int passed = 0, fails = 0, total = 0;

    always #5 clk = ~clk;

    function automatic int fmt_ew(int k);
        return k == 0 ? 8 : k == 1 ? 4 : 5;
    endfunction
    function automatic int fmt_mw(int k);
        return k == 0 ? 23 : k == 1 ? 3 : 10;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int EW = fmt_ew(g);
        localparam int MW = fmt_mw(g);
        logic [EW+MW:0] o;
        pipelined_floating_point_multiplier #(
            .EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW), .IGNORE_SIGN_BIT_FOR_NAN(1'b1)
        ) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .a(a[g][EW+MW:0]), .b(b[g][EW+MW:0]), .round_mode(rm[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out(o),
            .underflow_flag(uf[g]), .overflow_flag(of[g]), .invalid_operation_flag(inv[g]),
            .clear_flags(clr[g]), .sticky_underflow(s_uf[g]), .sticky_overflow(s_of[g]),
            .sticky_invalid(s_inv[g])
        );
        assign res[g] = 64'(o);
    end

    // exact product of the two significands, rounded by comparing the remainder with one half
    function automatic logic [66:0] model(int k, logic [63:0] x, logic [63:0] y, logic r);
        int ew, mw, s;
        logic [63:0] emax, mmask, ex, ey, fx, fy, sgn, inf, qn, p, m, rem, half;
        logic nx, ny;
        longint e;
        ew = fmt_ew(k);
        mw = fmt_mw(k);
        emax = (64'd1 << ew) - 1;
        mmask = (64'd1 << mw) - 1;
        ex = (x >> mw) & emax;
        ey = (y >> mw) & emax;
        fx = x & mmask;
        fy = y & mmask;
        sgn = ((x ^ y) >> (ew + mw)) & 64'd1;
        inf = (sgn << (ew + mw)) | (emax << mw);
        qn = (64'd1 << (ew + mw)) | (emax << mw) | ((ew == 4 && mw == 3) ? mmask : (64'd1 << (mw - 1)));
        nx = ex == emax && fx != 0;
        ny = ey == emax && fy != 0;
        if (nx || ny) return {2'b00, (nx && !fx[mw-1]) || (ny && !fy[mw-1]), qn};
        if ((ex == 0 && ey == emax) || (ex == emax && ey == 0)) return {3'b001, qn};
        if (ex == emax || ey == emax) return {3'b000, inf};
        if (ex == 0 || ey == 0) return {3'b000, sgn << (ew + mw)};
        p = ((64'd1 << mw) | fx) * ((64'd1 << mw) | fy);
        e = longint'(ex + ey) - longint'((1 << (ew - 1)) - 1);
        s = mw;
        if (p >= (64'd1 << (2 * mw + 1))) begin
            s = mw + 1;
            e++;
        end
        m = p >> s;
        rem = p & ((64'd1 << s) - 1);
        half = 64'd1 << (s - 1);
        if (r && (rem > half || (rem == half && m[0]))) m++;
        if (m == (64'd2 << mw)) begin
            m = m >> 1;
            e++;
        end
        if (e >= longint'(emax)) return {3'b010, inf};
        if (e <= 0) return {3'b100, sgn << (ew + mw)};
        return {3'b000, (sgn << (ew + mw)) | (64'(e) << mw) | (m & mmask)};
    endfunction

    function automatic logic [63:0] rnd_op(int k);
        int ew = fmt_ew(k);
        int mw = fmt_mw(k);
        logic [63:0] v;
        v = {$urandom, $urandom} & ((64'd1 << (ew + mw + 1)) - 1);
        if ($urandom_range(3) != 0)
            v = (v & ~(((64'd1 << ew) - 1) << mw)) | (64'((1 << (ew - 1)) - 2 + int'($urandom_range(3))) << mw);
        return v;
    endfunction

    function automatic logic [66:0] obs(int k);
        return {uf[k], of[k], inv[k], res[k]};
    endfunction

    task automatic check(string tag, logic [66:0] got, logic [66:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mon();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                sb[k].delete();
                st[k] = 3'b000;
            end else begin
                check($sformatf("sticky%0d", k), 67'({s_uf[k], s_of[k], s_inv[k]}), 67'(st[k]));
                if (out_valid[k] && out_ready[k]) begin
                    if (sb[k].size() == 0) check($sformatf("spurious%0d", k), 67'(out_valid[k]), 67'(0));
                    else check($sformatf("result%0d", k), obs(k), sb[k].pop_front());
                end
                st[k] = (st[k] & {3{!clr[k]}}) | ((out_valid[k] && out_ready[k]) ? {uf[k], of[k], inv[k]} : 3'b000);
                if (in_valid[k] && in_ready[k]) sb[k].push_back(model(k, a[k], b[k], rm[k]));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [63:0] x, logic [63:0] y, logic r, output int lat);
        in_valid[0] = 1'b1;
        a[0] = x;
        b[0] = y;
        rm[0] = r;
        tick();
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, acc, cnt;
        logic took, held_set;
        logic [66:0] held;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b1;
            rm[k] = 1'b1;
            clr[k] = 1'b0;
            a[k] = '0;
            b[k] = '0;
            st[k] = 3'b000;
        end
        tick();
        tick();
        check("rst_out", obs(0), 67'(0));
        check("rst_out_valid", 67'(out_valid[0]), 67'(0));
        check("rst_sticky", 67'({s_uf[0], s_of[0], s_inv[0]}), 67'(0));
        check("rst_in_ready", 67'(in_ready[0]), 67'(1));
        rst_n = 1'b1;
        tick();

        issue(64'h3FC00000, 64'h40000000, 1'b1, lat);
        check("latency", 67'(lat), 67'(2));
        check("mul_1p5x2", obs(0), {3'b000, 64'h40400000});
        issue(64'h3F800001, 64'h40400000, 1'b1, lat);
        check("tie_rne", obs(0), {3'b000, 64'h40400002});
        issue(64'h3F800001, 64'h40400000, 1'b0, lat);
        check("tie_rtz", obs(0), {3'b000, 64'h40400001});
        issue(64'h7F000000, 64'h40000000, 1'b1, lat);
        check("overflow", obs(0), {3'b010, 64'h7F800000});
        tick();
        check("sticky_of_set", 67'(s_of[0]), 67'(1));
        issue(64'h3FC00000, 64'h40000000, 1'b1, lat);
        tick();
        check("sticky_of_held", 67'(s_of[0]), 67'(1));
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("sticky_of_clear", 67'(s_of[0]), 67'(0));
        issue(64'h00000000, 64'h7F800000, 1'b1, lat);
        check("zero_x_inf", obs(0), {3'b001, 64'hFFC00000});
        issue(64'h7FC00000, 64'h3F800000, 1'b1, lat);
        check("qnan_operand", obs(0), {3'b000, 64'hFFC00000});
        issue(64'h80800000, 64'h00800000, 1'b1, lat);
        check("underflow", obs(0), {3'b100, 64'h80000000});
        issue(64'h7F000000, 64'h40000000, 1'b1, lat);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("clear_vs_set", 67'({s_uf[0], s_of[0], s_inv[0]}), 67'(3'b010));

        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1;
        a[0] = rnd_op(0);
        b[0] = rnd_op(0);
        acc = 0;
        held_set = 1'b0;
        held = '0;
        for (int i = 0; i < 6; i++) begin
            took = in_ready[0];
            acc += int'(took);
            if (out_valid[0]) begin
                if (held_set) check("bp_hold", obs(0), held);
                else begin
                    held = obs(0);
                    held_set = 1'b1;
                end
            end
            tick();
            if (took) begin
                a[0] = rnd_op(0);
                b[0] = rnd_op(0);
            end
        end
        check("bp_accepted", 67'(acc), 67'(3));
        check("bp_in_ready", 67'(in_ready[0]), 67'(0));
        check("bp_out_valid", 67'(out_valid[0]), 67'(1));
        check("bp_hold_final", obs(0), held);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        repeat (6) tick();
        check("bp_drained", 67'(sb[0].size()), 67'(0));

        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a[0] = rnd_op(0);
            b[0] = rnd_op(0);
            tick();
        end
        in_valid[0] = 1'b0;
        check("pre_rst_out_valid", 67'(out_valid[0]), 67'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", 67'(out_valid[0]), 67'(0));
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            tick();
            cnt += int'(out_valid[0]);
        end
        check("rst_no_results", 67'(cnt), 67'(0));

        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k] = $urandom_range(3) != 0;
                out_ready[k] = $urandom_range(3) != 0;
                rm[k] = 1'($urandom_range(1));
                clr[k] = $urandom_range(15) == 0;
                a[k] = rnd_op(k);
                b[k] = rnd_op(k);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b1;
            clr[k] = 1'b0;
        end
        repeat (8) tick();
        for (int k = 0; k < 3; k++) check($sformatf("drained%0d", k), 67'(sb[k].size()), 67'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
